// File: rtl/output_daemon.sv
// output_daemon: output-port collector of the 4x4 switch.
// Four source lanes, each buffered in a small FIFO, are merged by a
// round-robin arbiter into a single registered valid/ready output stage.
// Words that arrive on a full lane are discarded and counted.
module output_daemon #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [32:0]       from_input_buf_1,
  input  logic [32:0]       from_input_buf_2,
  input  logic [32:0]       from_input_buf_3,
  input  logic [32:0]       from_input_buf_4,
  output logic              buf_full_1,
  output logic              buf_full_2,
  output logic              buf_full_3,
  output logic              buf_full_4,
  input  logic              output_ready,
  output logic [31:0]       output_word,
  output logic              output_valid,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      mem    [4][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [4];
  logic [PTR_W-1:0] rd_ptr [4];
  logic [OCC_W-1:0] count  [4];
  logic [32:0]      lane_in[4];

  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] drop_vec;
  logic [3:0] pop;
  logic [2:0] n_drop;
  logic       load;
  logic [1:0] last_grant;
  logic [1:0] grant;
  logic [1:0] cand;
  logic       grant_vld;

  // Saturating add of this cycle's drops onto the running drop counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign lane_in[0] = from_input_buf_1;
  assign lane_in[1] = from_input_buf_2;
  assign lane_in[2] = from_input_buf_3;
  assign lane_in[3] = from_input_buf_4;

  assign buf_full_1 = full[0];
  assign buf_full_2 = full[1];
  assign buf_full_3 = full[2];
  assign buf_full_4 = full[3];

  // The stage accepts a new word when empty or when its word is being taken.
  assign load   = !output_valid || output_ready;
  assign n_drop = {2'b00, drop_vec[0]} + {2'b00, drop_vec[1]}
                + {2'b00, drop_vec[2]} + {2'b00, drop_vec[3]};

  // Lane write/drop decision uses the registered full flag only, so a pop
  // from a full lane never frees space for a write in the same cycle.
  always_comb begin
    full     = '0;
    push     = '0;
    drop_vec = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]     = (count[i] == OCC_W'(FIFO_DEPTH));
      push[i]     = lane_in[i][32] && !full[i];
      drop_vec[i] = lane_in[i][32] &&  full[i];
    end
  end

  // Round-robin scan starting after the last granted lane; only registered
  // occupancy is looked at, so a word pushed this cycle is not yet eligible.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    cand      = '0;
    pop       = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_vld && count[cand] != '0) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
    if (load && grant_vld) pop[grant] = 1'b1;
  end

  // FIFO storage; contents need no reset because pointers and counts do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= lane_in[i][31:0];
    end
  end

  // FIFO pointers and occupancy per lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + OCC_W'(1);
          2'b01:   count[i] <= count[i] - OCC_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output stage, round-robin pointer and drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      output_valid <= 1'b0;
      output_word  <= '0;
      last_grant   <= 2'd3;
      drop_count   <= '0;
    end else begin
      if (load) begin
        if (grant_vld) begin
          output_valid <= 1'b1;
          output_word  <= mem[grant][rd_ptr[grant]];
          last_grant   <= grant;
        end else begin
          output_valid <= 1'b0;
        end
      end
      drop_count <= sat_add(drop_count, n_drop);
    end
  end

endmodule

// File: doc/output_daemon.md
# output_daemon

Output-port side of the 4x4 switch: one instance per output port collects the 33-bit `{valid, word}` streams that the four input daemons address to this port. Each source lane is buffered in a small per-lane FIFO. Lanes are served by a round-robin arbiter, and one word per cycle is driven to the output port under a valid/ready handshake. Lane-full indications go back to the input daemons, and words that arrive while a lane is full are dropped and counted.

## Interface
- `FIFO_DEPTH`, default 4: per-lane FIFO depth. Must be a power of two, at least 2.
- `CNT_W`, default 16: width of the drop counter.

Ports:
- `clk`, in, 1: single clock. Everything is updated on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-low (reset when `rst`=0 at a rising edge of `clk`).
- `from_input_buf_1` .. `from_input_buf_4`, in, 33 each: one lane per input daemon. Bit 32 is valid; bits 31:0 are the word.
- `buf_full_1` .. `buf_full_4`, out, 1 each: lane FIFO holds `FIFO_DEPTH` entries.
- `output_ready`, in, 1: downstream accepts the word this cycle.
- `output_word`, out, 32: current output word.
- `output_valid`, out, 1: `output_word` is valid.
- `drop_count`, out, CNT_W: number of words dropped on full lanes. Saturates at all-ones.

## Operation
- **Reset** (`rst`=0 at an edge):
  - All FIFO counts and pointers go to 0.
  - `output_valid`=0, `output_word`=0, `drop_count`=0, all `buf_full_*`=0.
  - Round-robin pointer `last_grant` = lane 4, so lane 1 has first priority.
  - Reset overrides every other event in the same cycle.
- **Lane write:**
  - When bit 32 of a lane is 1 and `buf_full_n`=0, the word is pushed into that lane's FIFO.
  - When bit 32 is 1 and `buf_full_n`=1, the word is discarded and `drop_count` increments by 1 (saturating).
  - Several lanes dropping in the same cycle add their number of drops to the counter.
- **`buf_full_n`** is combinational from the registered count: count == `FIFO_DEPTH`.
  - A pop from a full lane in the same cycle does not make room for a same-cycle write; that write is dropped.
- **Output stage:** a single register holding `output_word` and `output_valid`.
  - The stage can load when `output_valid`=0, or when `output_valid`=1 and `output_ready`=1.
  - While `output_valid`=1 and `output_ready`=0, the stage holds and `output_word` stays stable.
- **Arbiter:** runs only in cycles where the stage can load.
  - Scans lanes starting at `last_grant`+1, wrapping from 4 back to 1, and picks the first non-empty FIFO.
  - Pops that lane's head into the output stage and sets `last_grant` to that lane.
  - If no lane is non-empty, it loads `output_valid`=0 and `last_grant` is unchanged.
  - Only the FIFO head is eligible, so a word pushed in cycle k cannot be granted in cycle k.
- **Same-lane push and pop in one cycle:** count is unchanged and both operations take effect.
- **FIFO pointers** wrap modulo `FIFO_DEPTH`. Count ranges 0..`FIFO_DEPTH`.
- **Ordering:** within a lane, words leave in arrival order. Across lanes, the only guarantee is round-robin fairness; a lane that is continuously non-empty is granted at least once every 4 grants.

## Timing
- **Latency:** a word presented at edge k (lane idle, stage free) has `output_valid`=1 with that word after edge k+1. Minimum latency is 2 edges.
- **Throughput:** 1 word per cycle while `output_ready`=1 and any lane is non-empty.
- **Backpressure:** `output_ready` low stalls the stage with no word lost. FIFOs keep accepting until full.
- **`buf_full_n`** rises in the cycle after the edge that writes the `FIFO_DEPTH`-th entry. It falls in the cycle after the first pop from that lane.
- **`drop_count`** updates at the edge where the drop happens and is visible the next cycle.
- **Reset mid-operation:** all buffered and in-flight words are discarded. The first word after reset follows the same 2-edge latency as above.

## Test plan
- **Reset values:** hold `rst`=0 for 2 cycles with all lanes driving valid words -> `output_valid`=0, `output_word`=0, `drop_count`=0, `buf_full_*`=0 throughout.
- **Single word:** lane 2 presents 0xDEADBEEF for one cycle at edge k, `output_ready`=1 -> `output_valid`=1 with 0xDEADBEEF after edge k+1, `output_valid`=0 after edge k+2.
- **Round robin:** all four lanes present words 0x1, 0x2, 0x3, 0x4 in the same cycle, `output_ready`=1 -> output sequence 0x1, 0x2, 0x3, 0x4 on consecutive cycles. A second burst 0x5..0x8 after edge 2 of the first burst continues lane order 1, 2, 3, 4.
- **Backpressure:** `output_ready`=0 with lane 3 streaming 0x10..0x15 and `FIFO_DEPTH`=4:
  - `output_word` holds 0x10.
  - `buf_full_3`=1 once 4 words are buffered.
  - 0x15 is dropped and `drop_count`=1.
  - Releasing `output_ready` yields 0x10..0x14 in order.
- **Full lane, pop and write in the same cycle:** with lane 1 full, `output_ready`=1, and a new word 0xAA presented -> the pop occurs, 0xAA is dropped, and `drop_count` increments.
- **Reset mid-stream:** assert `rst`=0 for one cycle while lanes 1-4 hold data -> all buffered words are gone, outputs return to reset values, and the next word on lane 4 is granted first with 2-edge latency.
